// File: rtl/mfp_ahb_lite_pkg.sv
// Shared AHB-Lite encodings for the mfp bus masters and slaves.
// Contents: HTRANS, HSIZE, HBURST, HPROT and HRESP constant codes.
package mfp_ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Data access, privileged, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/mfp_ahb_lite_single_master.sv
// AHB-Lite initiator: converts a valid/ready request stream into single NONSEQ transfers with
// overlapped address and data phases, and returns one response per transfer in request order.
// Ports:
//   HCLK, HRESET                 bus clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_addr/req_write/req_size  address-phase fields, driven onto the bus as-is
//   req_wdata                    write data, driven in the data phase
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion pulse with read data and error flag
//   HADDR..HWDATA                AHB master outputs
//   HRDATA/HREADY/HRESP          AHB slave returns
module mfp_ahb_lite_single_master
    import mfp_ahb_lite_pkg::*;
#(
    parameter int unsigned HADDR_WIDTH = 32,
    parameter int unsigned HDATA_WIDTH = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESET,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [HADDR_WIDTH-1:0] req_addr,
    input  logic                   req_write,
    input  logic [2:0]             req_size,
    input  logic [HDATA_WIDTH-1:0] req_wdata,

    output logic                   rsp_valid,
    output logic [HDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,

    output logic [HADDR_WIDTH-1:0] HADDR,
    output logic [1:0]             HTRANS,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    output logic                   HMASTLOCK,
    output logic [HDATA_WIDTH-1:0] HWDATA,

    input  logic [HDATA_WIDTH-1:0] HRDATA,
    input  logic                   HREADY,
    input  logic                   HRESP
);

    typedef enum logic [1:0] {
        AIdle,
        AActive,
        ASuppr
    } a_state_e;

    typedef enum logic {
        DIdle,
        DBusy
    } d_state_e;

    a_state_e a_state_q, a_state_d;
    d_state_e d_state_q, d_state_d;

    // Address-phase registers (current request on the bus).
    logic [HADDR_WIDTH-1:0] haddr_q;
    logic                   hwrite_q;
    logic [2:0]             hsize_q;
    logic [HDATA_WIDTH-1:0] a_wdata_q;

    // Data-phase registers (transfer whose data phase is in progress).
    logic                   d_write_q;
    logic [HDATA_WIDTH-1:0] hwdata_q;

    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic [HDATA_WIDTH-1:0] rsp_rdata_q;

    logic addr_done;
    logic data_done;
    logic req_take;
    logic resp_err;

    assign resp_err  = (HRESP == HRESP_ERROR);
    // Only a NONSEQ address phase hands a transfer to the data phase; the IDLE phase driven
    // while suppressed completes without creating one.
    assign addr_done = (a_state_q == AActive) && HREADY;
    assign data_done = (d_state_q == DBusy) && HREADY;

    // Combinational on HREADY so a new request can follow the previous one with no gap.
    assign req_ready = (a_state_q == AIdle) || ((a_state_q == AActive) && HREADY && !resp_err);
    assign req_take  = req_valid && req_ready;

    always_comb begin
        a_state_d = a_state_q;
        case (a_state_q)
            AIdle: begin
                if (req_valid) a_state_d = AActive;
            end
            AActive: begin
                if (HREADY) begin
                    a_state_d = req_take ? AActive : AIdle;
                end else if (resp_err) begin
                    // First error cycle: cancel the pending address, keep the request.
                    a_state_d = ASuppr;
                end
            end
            ASuppr: begin
                if (HREADY) a_state_d = AActive;
            end
            default: a_state_d = AIdle;
        endcase
    end

    always_comb begin
        d_state_d = d_state_q;
        if (addr_done) begin
            d_state_d = DBusy;
        end else if (data_done) begin
            d_state_d = DIdle;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_state_q <= AIdle;
            d_state_q <= DIdle;
        end else begin
            a_state_q <= a_state_d;
            d_state_q <= d_state_d;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= '0;
            a_wdata_q <= '0;
        end else if (req_take) begin
            haddr_q   <= req_addr;
            hwrite_q  <= req_write;
            hsize_q   <= req_size;
            a_wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            d_write_q <= 1'b0;
            hwdata_q  <= '0;
        end else if (addr_done) begin
            d_write_q <= hwrite_q;
            hwdata_q  <= a_wdata_q;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= data_done;
            if (data_done) begin
                rsp_err_q   <= resp_err;
                rsp_rdata_q <= d_write_q ? '0 : HRDATA;
            end
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = (a_state_q == AActive) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mfp_ahb_lite_single_master.sv
// Self-checking bench for mfp_ahb_lite_single_master: a scripted AHB slave plus a response
// scoreboard fed at request time and drained as rsp_valid pulses arrive.
module tb_mfp_ahb_lite_single_master;
    import mfp_ahb_lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    mfp_ahb_lite_single_master #(
        .HADDR_WIDTH(32),
        .HDATA_WIDTH(32)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        err;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    acc_cyc_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- scripted slave ----------------
    logic        s_busy, s_err, s_err_ph, s_write;
    int          s_wait;
    logic [31:0] s_wdata, s_rdata;
    logic        s_done;
    plan_t       cap;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        s_done = s_busy && (s_wait == 0) && (!s_err || s_err_ph);
        if (s_busy) begin
            if (s_wait > 0) begin
                HREADY = 1'b0;
            end else if (s_err) begin
                HRESP  = HRESP_ERROR;
                HREADY = s_err_ph;
            end
        end
        // Junk outside the completing cycle catches early or late sampling.
        if (s_done) HRDATA = s_write ? 32'h5A5A5A5A : s_rdata;
        else        HRDATA = 32'hBADBAD00;
    end

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s_busy   <= 1'b0;
            s_wait   <= 0;
            s_err    <= 1'b0;
            s_err_ph <= 1'b0;
            s_write  <= 1'b0;
            s_wdata  <= '0;
            s_rdata  <= '0;
        end else begin
            if (s_busy) begin
                if (s_wait > 0) begin
                    s_wait <= s_wait - 1;
                end else if (s_err && !s_err_ph) begin
                    s_err_ph <= 1'b1;
                end else begin
                    s_busy <= 1'b0;
                    if (s_write) check("hwdata", HWDATA, s_wdata);
                end
            end
            if (HREADY && HTRANS == HTRANS_NONSEQ) begin
                check("plan_avail", 32'(plan_q.size() > 0), 1);
                if (plan_q.size() > 0) begin
                    cap = plan_q.pop_front();
                    check("haddr", HADDR, cap.addr);
                    check("hwrite", 32'(HWRITE), 32'(cap.write));
                    check("hsize", 32'(HSIZE), 32'(cap.size));
                    s_busy   <= 1'b1;
                    s_wait   <= cap.waits;
                    s_err    <= cap.err;
                    s_err_ph <= 1'b0;
                    s_write  <= cap.write;
                    s_wdata  <= cap.wdata;
                    s_rdata  <= cap.rdata;
                end
            end
        end
    end

    // ---------------- accept monitor / cycle count ----------------
    int cyc = 0;
    int acc_cnt = 0;

    always @(posedge HCLK) begin
        cyc <= cyc + 1;
        if (!HRESET && req_valid && req_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc_q.push_back(cyc);
        end
    end

    // ---------------- output monitor ----------------
    int          run = 0, max_run = 0, n_wait_ns = 0, err2_seen = 0, rsp_cnt = 0, last_lat = 0;
    logic        err_window = 1'b0;
    logic        hold_chk = 1'b0, snap_resp;
    logic [31:0] snap_addr, snap_wdata;
    logic [1:0]  snap_trans;
    logic        snap_write;
    logic [2:0]  snap_size;
    exp_t        got_e;

    always @(negedge HCLK) begin
        if (HRESET) begin
            hold_chk = 1'b0;
        end else begin
            if (HTRANS == HTRANS_NONSEQ) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (HTRANS == HTRANS_NONSEQ && !HREADY) begin
                n_wait_ns++;
                check("req_ready_wait", 32'(req_ready), 0);
            end
            if (hold_chk) begin
                check("hold_haddr", HADDR, snap_addr);
                check("hold_hwdata", HWDATA, snap_wdata);
                check("hold_hwrite", 32'(HWRITE), 32'(snap_write));
                check("hold_hsize", 32'(HSIZE), 32'(snap_size));
                if (snap_resp == HRESP_OKAY) check("hold_htrans", 32'(HTRANS), 32'(snap_trans));
            end
            hold_chk   = !HREADY;
            snap_resp  = HRESP;
            snap_addr  = HADDR;
            snap_wdata = HWDATA;
            snap_write = HWRITE;
            snap_size  = HSIZE;
            snap_trans = HTRANS;
            if (err_window && HREADY && HRESP == HRESP_ERROR) begin
                err2_seen++;
                check("suppr_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
            end
            if (rsp_valid) begin
                rsp_cnt++;
                check("rsp_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    got_e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, got_e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(got_e.err));
                end
                if (acc_cyc_q.size() > 0) last_lat = cyc - acc_cyc_q.pop_front();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] addr, input logic write, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                        input logic err);
        plan_t p;
        exp_t  e;
        int    n;
        p.addr = addr; p.write = write; p.size = size; p.wdata = wdata;
        p.rdata = rdata; p.waits = waits; p.err = err;
        e.rdata = write ? 32'h0 : rdata;
        e.err   = err;
        plan_q.push_back(p);
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = write;
        req_size  = size;
        req_wdata = wdata;
        n = acc_cnt;
        for (int c = 0; c < 64 && acc_cnt == n; c++) @(negedge HCLK);
        check("accepted", 32'(acc_cnt - n), 1);
    endtask

    task automatic drain();
        int c = 0;
        req_valid = 1'b0;
        while (exp_q.size() > 0 && c < 64) begin
            @(negedge HCLK);
            c++;
        end
        check("drain", 32'(exp_q.size()), 0);
        repeat (2) @(negedge HCLK);
    endtask

    task automatic clr_run();
        @(posedge HCLK);
        #1;
        max_run = 0;
        @(negedge HCLK);
    endtask

    int rsp_before;

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_size  = HSIZE_WORD;
        req_wdata = '0;
        repeat (2) @(negedge HCLK);

        check("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check("rst_haddr", HADDR, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_hsize", 32'(HSIZE), 0);
        check("rst_hwrite", 32'(HWRITE), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("hburst", 32'(HBURST), 32'(HBURST_SINGLE));
        check("hprot", 32'(HPROT), 32'h3);
        check("hmastlock", 32'(HMASTLOCK), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        #2 HRESET = 1'b0;
        @(negedge HCLK);

        // Single zero-wait read.
        clr_run();
        send(32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'hCAFEF00D, 0, 1'b0);
        drain();
        check("read_latency", 32'(last_lat), 3);
        check("read_nonseq_cycles", 32'(max_run), 1);

        // Back-to-back writes with no IDLE gap.
        clr_run();
        send(32'h0, 1'b1, HSIZE_WORD, 32'd1, 32'h0, 0, 1'b0);
        send(32'h4, 1'b1, HSIZE_WORD, 32'd2, 32'h0, 0, 1'b0);
        send(32'h8, 1'b1, HSIZE_WORD, 32'd3, 32'h0, 0, 1'b0);
        drain();
        check("b2b_nonseq_run", 32'(max_run), 3);

        // Write with two wait states, read queued behind it.
        send(32'h20, 1'b1, HSIZE_WORD, 32'h11112222, 32'h0, 2, 1'b0);
        send(32'h24, 1'b0, HSIZE_WORD, 32'h0, 32'h24242424, 0, 1'b0);
        drain();
        check("wait_cycles_seen", 32'(n_wait_ns), 2);

        // Two-cycle ERROR on 0x30 with 0x34 pending behind it.
        err_window = 1'b1;
        send(32'h30, 1'b0, HSIZE_WORD, 32'h0, 32'h30303030, 0, 1'b1);
        send(32'h34, 1'b0, HSIZE_WORD, 32'h0, 32'h34343434, 0, 1'b0);
        drain();
        err_window = 1'b0;
        check("err2_cycles", 32'(err2_seen), 1);
        check("err_pending_wait", 32'(n_wait_ns), 3);

        // Byte write, address and lane data passed through unchanged.
        send(32'h41, 1'b1, HSIZE_BYTE, 32'h0000AB00, 32'h0, 0, 1'b0);
        drain();

        // Reset pulse during a stalled data phase.
        send(32'h50, 1'b0, HSIZE_WORD, 32'hDEAD0000, 32'h50505050, 3, 1'b0);
        req_valid = 1'b0;
        @(negedge HCLK);
        #2 HRESET = 1'b1;
        #1;
        check("arst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check("arst_haddr", HADDR, 0);
        check("arst_hwdata", HWDATA, 0);
        check("arst_hsize", 32'(HSIZE), 0);
        check("arst_rsp_valid", 32'(rsp_valid), 0);
        plan_q.delete();
        exp_q.delete();
        acc_cyc_q.delete();
        rsp_before = rsp_cnt;
        @(negedge HCLK);
        #2 HRESET = 1'b0;
        repeat (5) @(negedge HCLK);
        check("no_rsp_after_reset", 32'(rsp_cnt - rsp_before), 0);
        send(32'h54, 1'b0, HSIZE_WORD, 32'h0, 32'h54545454, 0, 1'b0);
        drain();

        check("final_empty", 32'(exp_q.size()), 0);
        check("rsp_total", 32'(rsp_cnt), 10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
